keypad_scanner: RTL and testbench

- Input-side counterpart of the multiplexed 7-segment display driver. The display scans strobes out; this block scans strobes out and reads sense lines back.
- Scans a 4x4 active-low matrix keypad at the 500 Hz system tick, debounces presses and reports one event per key.
- Accumulates up to two decimal digits into a slot/PIN entry value for the parking controller.

---
 rtl/keypad_scanner.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 4x4 active-low matrix keypad on the 500 Hz system tick, debounces
// key presses and releases, reports one event per accepted key, and builds a
// two-digit decimal entry (slot number / PIN) for the parking controller.
//
// Each column is driven low for 4 cycles. The synchronized row lines are
// sampled in the last of those cycles. A full scan of all four columns takes
// 16 cycles. The hits from one scan are classified as NONE, SINGLE or MULTI,
// and that result drives the debounce FSM.
//
// Ports:
//   clk_500Hz     in   1  system clock (2 ms period)
//   reset         in   1  synchronous reset, active-low
//   row_n         in   4  row sense lines, active-low, asynchronous
//   col_n         out  4  column drive, active-low, one-hot-low while scanning
//   key_code      out  4  last accepted key code
//   key_valid     out  1  one-cycle pulse when key_code is updated
//   entry_value   out  7  running entry value, 0..99
//   entry_digits  out  2  digits entered so far, 0..2
//   entry_result  out  7  entry value captured on '#'
//   entry_done    out  1  one-cycle pulse when entry_result is updated
//
// Optional feature macro: KEYPAD_AUTOREPEAT_EN
//   When defined, a held key is re-emitted every REPEAT_SCANS full scans.
//   When undefined, a press yields exactly one key_valid and no repeat
//   counter exists.
// -----------------------------------------------------------------------------
module keypad_scanner #(
    parameter int DEBOUNCE_SCANS = 3,
    parameter int REPEAT_SCANS   = 16
) (
    input  logic       clk_500Hz,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic [6:0] entry_value,
    output logic [1:0] entry_digits,
    output logic [6:0] entry_result,
    output logic       entry_done
);

    // Reject parameter values outside the supported range at elaboration.
    if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15 || REPEAT_SCANS < 1) begin : g_param_check
        $error("keypad_scanner: DEBOUNCE_SCANS must be 1..15, REPEAT_SCANS >= 1");
    end

    localparam logic [3:0] DEB_N     = 4'(DEBOUNCE_SCANS);
    localparam logic [3:0] CODE_STAR = 4'd14;
    localparam logic [3:0] CODE_HASH = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEB,
        ST_HELD,
        ST_REL
    } state_t;

    // Matrix position (row*4 + col) to key code.
    function automatic logic [3:0] key_map(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd0:    code = 4'd1;
            4'd1:    code = 4'd2;
            4'd2:    code = 4'd3;
            4'd3:    code = 4'd10;
            4'd4:    code = 4'd4;
            4'd5:    code = 4'd5;
            4'd6:    code = 4'd6;
            4'd7:    code = 4'd11;
            4'd8:    code = 4'd7;
            4'd9:    code = 4'd8;
            4'd10:   code = 4'd9;
            4'd11:   code = 4'd12;
            4'd12:   code = CODE_STAR;
            4'd13:   code = 4'd0;
            4'd14:   code = CODE_HASH;
            default: code = 4'd13;
        endcase
        return code;
    endfunction

    // Scan timing
    logic        run_q;
    logic [3:0]  scan_cnt_q;          // [3:2] = column, [1:0] = phase
    logic [3:0]  sync1_q, sync2_q;
    logic [15:0] hit_q, hit_d, hit_map;
    logic [3:0]  row_hit;
    logic [15:0] row_spread;
    logic        scan_end;

    // Scan classification
    logic [4:0]  hit_num;
    logic [3:0]  hit_idx;
    logic [3:0]  hit_code;
    logic        res_none, res_single;

    // Debounce FSM
    state_t      state_q, state_d;
    logic [3:0]  cand_q, cand_d;
    logic [3:0]  deb_cnt_q, deb_cnt_d;
    logic        emit;
    logic [3:0]  emit_code;

    // Event and entry outputs
    logic [3:0]  key_code_q;
    logic        key_valid_q;
    logic [6:0]  entry_value_q, entry_value_d;
    logic [1:0]  entry_digits_q, entry_digits_d;
    logic [6:0]  entry_result_q, entry_result_d;
    logic        entry_done_q, entry_done_d;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int              RPT_W = $clog2(REPEAT_SCANS + 1);
    localparam logic [RPT_W-1:0] RPT_N = RPT_W'(REPEAT_SCANS);
    logic [RPT_W-1:0] rep_cnt_q, rep_cnt_d;
`endif

    // Column drive stays released until scanning starts after reset.
    assign col_n    = run_q ? ~(4'b0001 << scan_cnt_q[3:2]) : 4'b1111;
    assign scan_end = run_q && (scan_cnt_q == 4'd15);

    // The sampled row bits land at positions row*4 + col of the hit map.
    assign row_hit    = ~sync2_q;
    assign row_spread = {3'b000, row_hit[3], 3'b000, row_hit[2],
                         3'b000, row_hit[1], 3'b000, row_hit[0]};

    always_comb begin
        hit_map = hit_q;
        if (run_q && scan_cnt_q[1:0] == 2'd3) begin
            hit_map = hit_q | (row_spread << scan_cnt_q[3:2]);
        end
        hit_d = scan_end ? 16'h0000 : hit_map;
    end

    always_comb begin
        hit_num = 5'd0;
        hit_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (hit_map[i]) begin
                hit_num = hit_num + 5'd1;
                hit_idx = 4'(i);
            end
        end
    end

    assign res_none   = (hit_num == 5'd0);
    assign res_single = (hit_num == 5'd1);
    assign hit_code   = key_map(hit_idx);

    // Debounce FSM next state; evaluated only on the last cycle of a scan.
    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        deb_cnt_d = deb_cnt_q;
        emit      = 1'b0;
        emit_code = key_code_q;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_cnt_d = rep_cnt_q;
`endif
        if (scan_end) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (res_single) begin
                        cand_d    = hit_code;
                        deb_cnt_d = 4'd1;
                        if (DEB_N == 4'd1) begin
                            state_d   = ST_HELD;
                            emit      = 1'b1;
                            emit_code = hit_code;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_cnt_d = '0;
`endif
                        end else begin
                            state_d = ST_DEB;
                        end
                    end
                end
                ST_DEB: begin
                    if (res_single && hit_code == cand_q) begin
                        if (deb_cnt_q + 4'd1 == DEB_N) begin
                            state_d   = ST_HELD;
                            emit      = 1'b1;
                            emit_code = cand_q;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_cnt_d = '0;
`endif
                        end else begin
                            deb_cnt_d = deb_cnt_q + 4'd1;
                        end
                    end else if (res_single) begin
                        cand_d    = hit_code;
                        deb_cnt_d = 4'd1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_HELD: begin
                    // MULTI counts as "still pressed" here.
                    if (res_none) begin
                        deb_cnt_d = 4'd1;
                        state_d   = (DEB_N == 4'd1) ? ST_IDLE : ST_REL;
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    else if (rep_cnt_q + RPT_W'(1) == RPT_N) begin
                        emit      = 1'b1;
                        emit_code = key_code_q;
                        rep_cnt_d = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + RPT_W'(1);
                    end
`endif
                end
                ST_REL: begin
                    if (res_none) begin
                        if (deb_cnt_q + 4'd1 == DEB_N) begin
                            state_d = ST_IDLE;
                        end else begin
                            deb_cnt_d = deb_cnt_q + 4'd1;
                        end
                    end else begin
                        state_d = ST_HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_cnt_d = '0;
`endif
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Entry accumulator; acts on the cycle key_valid is high.
    always_comb begin
        entry_value_d  = entry_value_q;
        entry_digits_d = entry_digits_q;
        entry_result_d = entry_result_q;
        entry_done_d   = 1'b0;
        if (key_valid_q) begin
            if (key_code_q <= 4'd9) begin
                // At most two digits, so the value never exceeds 99.
                if (entry_digits_q < 2'd2) begin
                    entry_value_d  = entry_value_q * 7'd10 + {3'b000, key_code_q};
                    entry_digits_d = entry_digits_q + 2'd1;
                end
            end else if (key_code_q == CODE_STAR) begin
                entry_value_d  = 7'd0;
                entry_digits_d = 2'd0;
            end else if (key_code_q == CODE_HASH && entry_digits_q != 2'd0) begin
                entry_result_d = entry_value_q;
                entry_done_d   = 1'b1;
                entry_value_d  = 7'd0;
                entry_digits_d = 2'd0;
            end
        end
    end

    always_ff @(posedge clk_500Hz) begin
        if (!reset) begin
            run_q          <= 1'b0;
            scan_cnt_q     <= 4'd0;
            // Idle level of the row lines, so nothing reads as pressed.
            sync1_q        <= 4'b1111;
            sync2_q        <= 4'b1111;
            hit_q          <= 16'h0000;
            state_q        <= ST_IDLE;
            cand_q         <= 4'd0;
            deb_cnt_q      <= 4'd0;
            key_code_q     <= 4'd0;
            key_valid_q    <= 1'b0;
            entry_value_q  <= 7'd0;
            entry_digits_q <= 2'd0;
            entry_result_q <= 7'd0;
            entry_done_q   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_q      <= '0;
`endif
        end else begin
            run_q          <= 1'b1;
            if (run_q) begin
                scan_cnt_q <= scan_cnt_q + 4'd1;
            end
            sync1_q        <= row_n;
            sync2_q        <= sync1_q;
            hit_q          <= hit_d;
            state_q        <= state_d;
            cand_q         <= cand_d;
            deb_cnt_q      <= deb_cnt_d;
            key_valid_q    <= emit;
            if (emit) begin
                key_code_q <= emit_code;
            end
            entry_value_q  <= entry_value_d;
            entry_digits_q <= entry_digits_d;
            entry_result_q <= entry_result_d;
            entry_done_q   <= entry_done_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_q      <= rep_cnt_d;
`endif
        end
    end

    assign key_code     = key_code_q;
    assign key_valid    = key_valid_q;
    assign entry_value  = entry_value_q;
    assign entry_digits = entry_digits_q;
    assign entry_result = entry_result_q;
    assign entry_done   = entry_done_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//
// Testbench for keypad_scanner. A keypad model turns the set of pressed keys
// into row_n levels for the column currently driven low. Key changes happen
// at scan boundaries, so one set of pressed keys applies to a whole scan. A
// reference model works on whole scans: it classifies the pressed set, applies
// the press/release debounce rules, and then applies the digit-entry rules.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_keypad_scanner;

    localparam int D = 3;
    localparam int R = 16;

    logic       clk_500Hz;
    logic       reset;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic [6:0] entry_value;
    logic [1:0] entry_digits;
    logic [6:0] entry_result;
    logic       entry_done;

    logic [15:0] keys;   // bit row*4+col set = key pressed

    keypad_scanner #(
        .DEBOUNCE_SCANS(D),
        .REPEAT_SCANS  (R)
    ) dut (
        .clk_500Hz   (clk_500Hz),
        .reset       (reset),
        .row_n       (row_n),
        .col_n       (col_n),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .entry_value (entry_value),
        .entry_digits(entry_digits),
        .entry_result(entry_result),
        .entry_done  (entry_done)
    );

    initial begin
        clk_500Hz = 1'b0;
        forever #5 clk_500Hz = ~clk_500Hz;
    end

    // Passive matrix: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row_n = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4 + c] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    // Key code at each matrix position (row*4 + col).
    int keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Reference model state
    int  exp_kv, exp_code, exp_val, exp_dig, exp_res, exp_done;
    bit  m_down;           // a key has been accepted and not yet released
    int  m_run;            // consecutive identical single-key scans while up
    int  m_last;           // key of that run
    int  m_none;           // consecutive empty scans while down
`ifdef KEYPAD_AUTOREPEAT_EN
    int  m_held;           // scans held since last event or re-press
`endif

    task automatic model_reset();
        exp_kv = 0; exp_code = 0; exp_val = 0; exp_dig = 0; exp_res = 0; exp_done = 0;
        m_down = 1'b0; m_run = 0; m_last = 0; m_none = 0;
`ifdef KEYPAD_AUTOREPEAT_EN
        m_held = 0;
`endif
    endtask

    task automatic model_entry(input int code);
        if (code <= 9) begin
            if (exp_dig < 2) begin
                exp_val = exp_val * 10 + code;
                exp_dig = exp_dig + 1;
            end
        end else if (code == 14) begin
            exp_val = 0;
            exp_dig = 0;
        end else if (code == 15 && exp_dig >= 1) begin
            exp_res  = exp_val;
            exp_done = 1;
            exp_val  = 0;
            exp_dig  = 0;
        end
    endtask

    task automatic model_scan(input logic [15:0] k);
        int n;
        int code;
        bit ev;
        n    = $countones(k);
        code = 0;
        for (int i = 0; i < 16; i++) if (k[i]) code = keymap[i];
        ev = 1'b0;
        if (m_down) begin
            if (n == 0) begin
                m_none++;
                if (m_none >= D) begin
                    m_down = 1'b0;
                    m_run  = 0;
                end
            end else if (m_none > 0) begin
                m_none = 0;
`ifdef KEYPAD_AUTOREPEAT_EN
                m_held = 0;
`endif
            end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                m_held++;
                if (m_held == R) begin
                    ev     = 1'b1;
                    code   = exp_code;
                    m_held = 0;
                end
`endif
            end
        end else if (n == 1) begin
            m_run  = (m_run > 0 && code == m_last) ? m_run + 1 : 1;
            m_last = code;
            if (m_run >= D) begin
                ev     = 1'b1;
                m_down = 1'b1;
                m_none = 0;
`ifdef KEYPAD_AUTOREPEAT_EN
                m_held = 0;
`endif
            end
        end else begin
            m_run = 0;
        end
        exp_kv   = ev ? 1 : 0;
        exp_done = 0;
        if (ev) begin
            exp_code = code;
            model_entry(code);
        end
    endtask

    // Called on the negedge of a scan's last cycle (or just after reset
    // release); runs one full scan with the given pressed set.
    task automatic do_scan(input logic [15:0] k);
        int bad;
        int stray;
        logic [3:0] exp_col;
        @(negedge clk_500Hz);
        check("key_valid", key_valid, exp_kv);
        check("key_code", key_code, exp_code);
        check("col_n_c0", col_n, 4'b1110);
        keys  = k;
        bad   = 0;
        stray = 0;
        for (int i = 1; i < 16; i++) begin
            @(negedge clk_500Hz);
            exp_col = ~(4'b0001 << (i / 4));
            if (col_n != exp_col) bad++;
            if (key_valid) stray++;
            if (i == 1) begin
                check("entry_value", entry_value, exp_val);
                check("entry_digits", entry_digits, exp_dig);
                check("entry_result", entry_result, exp_res);
                check("entry_done", entry_done, exp_done);
            end else if (entry_done) begin
                stray++;
            end
        end
        check("col_walk", bad, 0);
        check("stray_pulse", stray, 0);
        model_scan(k);
    endtask

    task automatic hold(input logic [15:0] k, input int n);
        for (int i = 0; i < n; i++) do_scan(k);
    endtask

    task automatic do_reset(input int n);
        keys  = 16'h0000;
        reset = 1'b0;
        for (int i = 0; i < n; i++) @(negedge clk_500Hz);
        check("rst_col_n", col_n, 4'b1111);
        check("rst_key_code", key_code, 0);
        check("rst_key_valid", key_valid, 0);
        check("rst_entry_value", entry_value, 0);
        check("rst_entry_digits", entry_digits, 0);
        check("rst_entry_result", entry_result, 0);
        check("rst_entry_done", entry_done, 0);
        model_reset();
        reset = 1'b1;
    endtask

    function automatic logic [15:0] key_mask(input int code);
        logic [15:0] m;
        m = 16'h0000;
        for (int i = 0; i < 16; i++) if (keymap[i] == code) m[i] = 1'b1;
        return m;
    endfunction

    // Press for n scans, then release for D+1 scans.
    task automatic tap(input int code, input int n);
        hold(key_mask(code), n);
        hold(16'h0000, D + 1);
    endtask

    int          sel;
    int          code;
    logic [15:0] m;

    initial begin
        keys  = 16'h0000;
        reset = 1'b0;
        model_reset();

        // Reset and idle scanning
        do_reset(5);
        hold(16'h0000, 3);

        // '5' held for about 200 ms
        hold(key_mask(5), 7);
        hold(16'h0000, D + 1);
        check("t5_code", key_code, 5);
        check("t5_value", entry_value, 5);
        check("t5_digits", entry_digits, 1);

        // Clear, then 4, 2, '#'
        tap(14, D + 1);
        tap(4, D + 1);
        tap(2, D + 1);
        tap(15, D + 1);
        check("t42_result", entry_result, 42);
        check("t42_value", entry_value, 0);
        check("t42_digits", entry_digits, 0);

        // 9, 9, 9, '*'
        tap(9, D + 1);
        tap(9, D + 1);
        check("t99_value", entry_value, 99);
        tap(9, D + 1);
        check("t99_third", entry_value, 99);
        check("t99_digits", entry_digits, 2);
        tap(14, D + 1);
        check("tstar_value", entry_value, 0);
        check("tstar_digits", entry_digits, 0);

        // '7' bouncing, then stable
        hold(key_mask(7), 1);
        hold(16'h0000, 1);
        hold(key_mask(7), 1);
        hold(16'h0000, 1);
        hold(key_mask(7), 1);
        hold(16'h0000, 1);
        hold(key_mask(7), 5);
        hold(16'h0000, D + 1);
        check("tbounce_code", key_code, 7);

        // '1' and '2' together
        hold(key_mask(1) | key_mask(2), 6);
        hold(16'h0000, D + 1);
        check("tmulti_code", key_code, 7);

        // Reset between digits discards the partial entry
        tap(3, D + 1);
        check("tpart_digits", entry_digits, 2);
        do_reset(3);
        tap(15, D + 1);
        check("tpart_result", entry_result, 0);
        check("tpart_digits2", entry_digits, 0);

        // 'B' held for about 2 s
        hold(key_mask(11), 63);
        hold(16'h0000, D + 1);
        check("tB_code", key_code, 11);

        // Random presses, glitches, chords, short releases and resets
        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(0, 19);
            if (sel < 11)      code = $urandom_range(0, 9);
            else if (sel < 13) code = 14;
            else if (sel < 16) code = 15;
            else               code = $urandom_range(10, 13);
            m = key_mask(code);
            if (sel == 19) m = m | key_mask($urandom_range(0, 9));
            hold(m, $urandom_range(1, D + 3));
            hold(16'h0000, $urandom_range(1, D + 2));
            if ($urandom_range(0, 24) == 0) do_reset(2);
        end
        hold(16'h0000, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
